// File: rtl/usart_pkg.sv
// Shared constants for the parametrised USART receive path: parity modes,
// receiver state encoding and frame-length helper.
package usart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Number of bit periods that follow the data bits (optional parity + stops).
  function automatic int frame_tail_bits(input int parity, input int stop_bits);
    return ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// Line conditioning for the receiver: synchroniser, falling-edge detect and
// 3-sample majority vote over the synchronised line.
module usart_rx_sampler
  import usart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall,
  output logic o_maj
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_hist;
  logic                   w_rx_s;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Reset to idle-high so a released reset never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_hist <= 2'b11;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign o_rx_s = w_rx_s;
  assign o_fall = r_hist[0] & ~w_rx_s;
  assign o_maj  = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);

endmodule

// File: rtl/usart_rx_param.sv
// Parametrised USART receiver: frame FSM, data shift register, parity/framing
// status and a single-entry holding register behind a valid/ready handshake.
module usart_rx_param
  import usart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int BW       = $clog2(DATA_BITS + 3);
  localparam int LAST_BIT = DATA_BITS + frame_tail_bits(PARITY, STOP_BITS) - 1;

  localparam logic [CW-1:0] HALF_CNT   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(LAST_BIT);

  logic                 w_rx_s;
  logic                 w_fall;
  logic                 w_maj;
  logic                 w_tick;
  logic                 w_ferr_next;
  logic                 w_perr_next;
  logic                 w_accept;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_done;

  logic [DATA_BITS-1:0] r_hold_data;
  logic                 r_hold_perr;
  logic                 r_hold_ferr;
  logic                 r_valid;
  logic                 r_ovr;

  usart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_rx    (rx),
    .o_rx_s  (w_rx_s),
    .o_fall  (w_fall),
    .o_maj   (w_maj)
  );

  assign w_tick      = (r_cnt == FULL_CNT);
  assign w_ferr_next = r_ferr | ~w_maj;
  // r_par holds the XOR of the data bits; odd parity wants the total to be 1.
  assign w_perr_next = (PARITY == PARITY_ODD) ? ~(r_par ^ w_maj) : (r_par ^ w_maj);
  assign w_accept    = r_valid & rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt   <= '0;
            r_state <= w_maj ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_bit   <= r_bit + 1'b1;
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_maj;
            if (r_bit == DATA_LAST) begin
              r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_bit   <= r_bit + 1'b1;
            r_perr  <= w_perr_next;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_bit  <= r_bit + 1'b1;
            r_ferr <= w_ferr_next;
            // Returning to IDLE mid-stop lets the next start edge be caught
            // without an idle gap; an all-zero framed character is a break.
            if (r_bit == FRAME_LAST) begin
              r_done  <= 1'b1;
              r_state <= (w_ferr_next && (r_shift == '0)) ? ST_BREAK : ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register: a completion that finds the slot full and not being
  // drained is dropped and flagged as overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_data <= '0;
      r_hold_perr <= 1'b0;
      r_hold_ferr <= 1'b0;
      r_valid     <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (r_done) begin
        if (!r_valid || w_accept) begin
          r_hold_data <= r_shift;
          r_hold_perr <= r_perr;
          r_hold_ferr <= r_ferr;
          r_valid     <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_hold_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_hold_perr;
  assign frame_err  = r_hold_ferr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usart_rx_param.sv
// Directed bench for usart_rx_param: default 8N1 at 434 clk/bit, an 8E1 and a
// 9N2 variant at 16 clk/bit, each driven by its own serial line.
module tb_usart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset2;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;

  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic v0, v1, v2, p0, p1, p2, f0, f1, f2, o0, o1, o2, b0, b1, b2;

  usart_rx_param u_dut0 (
    .clk(clk), .reset(reset0), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(p0), .frame_err(f0), .overrun(o0), .busy(b0)
  );

  usart_rx_param #(.CLKS_PER_BIT(16), .PARITY(2)) u_dut1 (
    .clk(clk), .reset(reset0), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(p1), .frame_err(f1), .overrun(o1), .busy(b1)
  );

  usart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(9), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset2), .rx(rx2), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
    .parity_err(p2), .frame_err(f2), .overrun(o2), .busy(b2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc[3] = '{0, 0, 0};
  int vh[3]  = '{0, 0, 0};
  int ovr[3] = '{0, 0, 0};
  int llat[3] = '{0, 0, 0};
  int start_cyc[3] = '{0, 0, 0};
  logic [8:0] ldata[3];
  logic lperr[3];
  logic lferr[3];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted character per DUT, sampled away from the active edge.
  always @(negedge clk) begin
    if (v0) vh[0] <= vh[0] + 1;
    if (v1) vh[1] <= vh[1] + 1;
    if (v2) vh[2] <= vh[2] + 1;
    if (o0) ovr[0] <= ovr[0] + 1;
    if (o1) ovr[1] <= ovr[1] + 1;
    if (o2) ovr[2] <= ovr[2] + 1;
    if (v0 && rdy0) begin
      acc[0] <= acc[0] + 1; ldata[0] <= {1'b0, d0}; lperr[0] <= p0; lferr[0] <= f0;
      llat[0] <= cyc - start_cyc[0];
    end
    if (v1 && rdy1) begin
      acc[1] <= acc[1] + 1; ldata[1] <= {1'b0, d1}; lperr[1] <= p1; lferr[1] <= f1;
    end
    if (v2 && rdy2) begin
      acc[2] <= acc[2] + 1; ldata[2] <= d2; lperr[2] <= p2; lferr[2] <= f2;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Caller must be at posedge+1; returns at posedge+1 with the line left at
  // the last stop value.
  task automatic send_frame(input int sel, input int cpb, input logic [8:0] data,
                            input int nbits, input int has_par, input logic par_bit,
                            input int nstop, input logic stop_val);
    start_cyc[sel] = cyc;
    drive(sel, 1'b0);
    repeat (cpb) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      repeat (cpb) @(posedge clk);
      #1;
    end
    if (has_par != 0) begin
      drive(sel, par_bit);
      repeat (cpb) @(posedge clk);
      #1;
    end
    for (int i = 0; i < nstop; i++) begin
      drive(sel, stop_val);
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  int a, v, o, bcnt;
  logic [8:0] pat;

  initial begin
    reset0 = 1'b0;
    reset2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(v0), 0);
    check("rst_busy", int'(b0), 0);
    check("rst_data", int'(d0), 0);
    check("rst_perr", int'(p0), 0);
    check("rst_ferr", int'(f0), 0);
    check("rst_ovr", int'(o0), 0);
    reset0 = 1'b1;
    reset2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 0x0A with the consumer always ready
    a = acc[0]; v = vh[0];
    send_frame(0, 434, 9'h00A, 8, 0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("t1_count", acc[0] - a, 1);
    check("t1_pulse", vh[0] - v, 1);
    check("t1_data", int'(ldata[0]), 'h0A);
    check("t1_perr", int'(lperr[0]), 0);
    check("t1_ferr", int'(lferr[0]), 0);
    check("t1_latency", int'(llat[0] >= 4120 && llat[0] <= 4136), 1);

    // 100-cycle glitch must be rejected at the start-bit sample point
    a = acc[0]; bcnt = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      rx0 = (i < 100) ? 1'b0 : 1'b1;
      if (b0) bcnt++;
    end
    check("t2_no_char", acc[0] - a, 0);
    check("t2_busy_short", int'(bcnt > 0 && bcnt < 220), 1);
    check("t2_idle", int'(b0), 0);
    @(posedge clk);
    #1;

    // Even parity: 0x55 has four ones, so parity bit 1 is wrong and 0 is right
    a = acc[1];
    send_frame(1, 16, 9'h055, 8, 1, 1'b1, 1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("t3a_count", acc[1] - a, 1);
    check("t3a_data", int'(ldata[1]), 'h55);
    check("t3a_perr", int'(lperr[1]), 1);
    check("t3a_ferr", int'(lferr[1]), 0);
    send_frame(1, 16, 9'h055, 8, 1, 1'b0, 1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("t3b_count", acc[1] - a, 2);
    check("t3b_data", int'(ldata[1]), 'h55);
    check("t3b_perr", int'(lperr[1]), 0);

    // Back-to-back frames with the consumer stalled: second one overruns
    rdy0 = 1'b0;
    o = ovr[0];
    send_frame(0, 434, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    send_frame(0, 434, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_held_valid", int'(v0), 1);
    check("t4_held_data", int'(d0), 'h11);
    check("t4_overrun", ovr[0] - o, 1);
    #1 rdy0 = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", int'(v0), 0);
    @(posedge clk);
    #1;

    // Break: 0x00 with a low stop bit, line held low for three frame times
    a = acc[0]; v = vh[0];
    send_frame(0, 434, 9'h000, 8, 0, 1'b0, 1, 1'b0);
    repeat (3 * 4340) @(posedge clk);
    #1;
    check("t5_count", acc[0] - a, 1);
    check("t5_pulse", vh[0] - v, 1);
    check("t5_data", int'(ldata[0]), 0);
    check("t5_ferr", int'(lferr[0]), 1);
    check("t5_in_break", int'(b0), 1);
    rx0 = 1'b1;
    repeat (868) @(posedge clk);
    #1;
    check("t5_no_spurious", acc[0] - a, 1);
    check("t5_idle", int'(b0), 0);
    send_frame(0, 434, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("t5_next_count", acc[0] - a, 2);
    check("t5_next_data", int'(ldata[0]), 'hA5);
    check("t5_next_ferr", int'(lferr[0]), 0);

    // 9N2: reset mid-data, then a clean 0x1A5
    a = acc[2];
    pat = 9'h1A5;
    drive(2, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(2, pat[i]);
      repeat (16) @(posedge clk);
      #1;
    end
    repeat (8) @(posedge clk);
    #1;
    check("t6_busy_mid", int'(b2), 1);
    reset2 = 1'b0;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_valid", int'(v2), 0);
    check("t6_rst_busy", int'(b2), 0);
    check("t6_rst_data", int'(d2), 0);
    check("t6_rst_ferr", int'(f2), 0);
    reset2 = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    check("t6_no_stray", acc[2] - a, 0);
    send_frame(2, 16, 9'h1A5, 9, 0, 1'b0, 2, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("t6_count", acc[2] - a, 1);
    check("t6_data", int'(ldata[2]), 'h1A5);
    check("t6_ferr", int'(lferr[2]), 0);
    check("t6_perr", int'(lperr[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usart_rx_param.md
Name: usart_rx_param

Overview:
Parametrised USART receiver that succeeds the fixed 8N1 receive path in USART_Controller. It adds configurable data width, parity, stop-bit count, glitch-rejecting start detection and 3-sample majority voting. Received characters are delivered through a valid/ready handshake, with per-character parity and framing status plus an overrun indication. It sits between the rx pad and the controller's receive datapath.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (>=8); 434 = 50 MHz / 115200
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, rx synchroniser depth (>=2)

Ports:
clk  in  1  single clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received character
rx_valid  out  1  rx_data/parity_err/frame_err valid; held until accepted
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the held character (0 when PARITY=0)
frame_err  out  1  any stop bit sampled low for the held character
overrun  out  1  one-cycle pulse: completed character dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0; synchroniser flops set to 1 (no false start); rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- rx_s is rx after SYNC_STAGES flops. Each sample is the majority of rx_s over 3 consecutive cycles. The decision is taken on the third of those cycles, the "sample point".
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rx_s 1->0, clear the cycle counter and go to START.
- START: sample point at count CLKS_PER_BIT/2 (integer division). If the sample is 0, go to DATA; if 1, it is a glitch and the FSM returns to IDLE.
- In DATA, PARITY and STOP, each subsequent sample point is exactly CLKS_PER_BIT cycles after the previous one.
- DATA: shift DATA_BITS samples LSB first.
- PARITY: present only if PARITY!=0. Error when the XOR of the data bits and the parity bit is 0 for odd, or 1 for even.
- STOP: STOP_BITS samples; any 0 sets frame_err for this character.
- Completion: the cycle after the last stop-bit sample point, load the holding register and assert rx_valid.
- After completion the FSM goes to IDLE, so a following start edge is detected mid-stop. Back-to-back frames need no idle gap.
- BREAK: if frame_err=1 and all data bits are 0, deliver the character, then wait in BREAK until rx_s=1 before IDLE. No spurious start follows a break.
- Handshake: rx_valid drops the cycle after rx_valid && rx_ready. rx_data and flags are stable while rx_valid=1 and not accepted.
- Completion with rx_valid=1 and no accept in the same cycle: the new character is discarded, the held one is kept, overrun pulses for 1 cycle.
- Completion in the same cycle as an accept: the new character loads, rx_valid stays 1, no overrun.
- Asynchronous reset mid-frame aborts the frame immediately. No partial character is delivered after reset is released.
- Counter width is $clog2(CLKS_PER_BIT). The bit counter is wide enough for DATA_BITS+2.

Decomposition:
- Package usart_pkg holds the PARITY_NONE/ODD/EVEN constants, the rx state encoding, and a function computing stop/parity frame length from the parameters.
- One natural sub-module, usart_rx_sampler, contains the SYNC_STAGES synchroniser, falling-edge detect and 3-sample majority voter.
- Top level holds the FSM, shift register, holding register and handshake.

Test Plan:
1. Defaults, rx_ready=1; drive start, data LSB-first 0,1,0,1,0,0,0,0, stop 1, 434 clk/bit -> rx_data=0x0A, rx_valid pulses 1 cycle, parity_err=0, frame_err=0, asserted ~(9.5*434+3) cycles after the start edge.
2. Glitch: rx low for 100 clk, then high -> FSM returns to IDLE; rx_valid never asserts; busy high for under 220 cycles.
3. PARITY=2, send 0x55 with parity bit 1 -> rx_data=0x55, parity_err=1; repeat with parity bit 0 -> parity_err=0.
4. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses once at the second completion. Assert rx_ready -> rx_valid falls next cycle.
5. Send 0x00 with stop=0 and hold rx low for 3 frame times -> one character 0x00 with frame_err=1; no further rx_valid until rx goes high and a new frame arrives.
6. DATA_BITS=9, STOP_BITS=2, CLKS_PER_BIT=16; pull reset low mid-DATA, then send 0x1A5 -> outputs 0 during reset, single rx_data=0x1A5 afterwards, no stray character.
